// File: rtl/sigmoid_pkg.sv
// Shared FP32 constants, arbiter state encoding and saturation helpers
// for the sigmoid arbiter slice.
package sigmoid_pkg;

  localparam logic [31:0] FP_ONE          = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO         = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN         = 32'h7FC0_0000;
  localparam int          SAT_EXP_DEFAULT = 130;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  function automatic logic isSaturated(input logic [31:0] x, input int satExp);
    return int'(x[30:23]) > satExp;
  endfunction

  // Large |x| (including Inf/NaN) collapses onto the sign-selected asymptote.
  function automatic logic [31:0] saturatedValue(input logic [31:0] x);
    return x[31] ? FP_ZERO : FP_ONE;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first asserted request at or after
// ptr_i, wrapping modulo N_REQ.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  winner_o,
  output logic             any_o
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    winner_o = '0;
    idx      = '0;
    any_o    = |req_i;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = ID_W'((int'(ptr_i) + off) % N_REQ);
      if (req_i[idx]) begin
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Round-robin scheduler sharing one FP32 sigmoid unit between N_REQ requesters,
// with saturation bypass and a bounded wait that aborts stuck jobs.
module sigmoid_arbiter
  import sigmoid_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 16,
  parameter  int SAT_EXP = SAT_EXP_DEFAULT,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                clk_i,
  input  logic                res_i,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [32*N_REQ-1:0] req_num_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic                resp_valid_o,
  output logic [ID_W-1:0]     resp_id_o,
  output logic [31:0]         resp_data_o,
  output logic                resp_err_o,
  output logic                busy_o,
  output logic                sig_start_o,
  output logic [31:0]         sig_num_o,
  input  logic                sig_done_i,
  input  logic [31:0]         sig_result_i,
  output logic                sig_res_o
);

  localparam int                WCNT_W    = $clog2(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]  GNT_LSB   = N_REQ'(1);

  arb_state_e        state_q;
  logic [ID_W-1:0]   rrPtr_q;
  logic [ID_W-1:0]   id_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [N_REQ-1:0]  gnt_q;
  logic              respValid_q;
  logic [ID_W-1:0]   respId_q;
  logic [31:0]       respData_q;
  logic              respErr_q;
  logic              busy_q;
  logic              sigStart_q;
  logic [31:0]       sigNum_q;
  logic              abort_q;

  logic [ID_W-1:0]   winner_d;
  logic              anyReq_d;
  logic [31:0]       winOp_d;
  logic [ID_W-1:0]   nextPtr_d;
  logic [31:0]       reqOps [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      reqOps[i] = req_num_i[32*i +: 32];
    end
  end

  rr_picker #(.N_REQ(N_REQ)) uPicker (
    .req_i    (req_i),
    .ptr_i    (rrPtr_q),
    .winner_o (winner_d),
    .any_o    (anyReq_d)
  );

  assign winOp_d   = reqOps[winner_d];
  assign nextPtr_d = (id_q == LAST_ID) ? '0 : id_q + 1'b1;

  // Pulsed outputs default low; each state only raises what it owns for one cycle.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q     <= S_IDLE;
      rrPtr_q     <= '0;
      id_q        <= '0;
      wcnt_q      <= '0;
      gnt_q       <= '0;
      respValid_q <= 1'b0;
      respId_q    <= '0;
      respData_q  <= '0;
      respErr_q   <= 1'b0;
      busy_q      <= 1'b0;
      sigStart_q  <= 1'b0;
      sigNum_q    <= '0;
      abort_q     <= 1'b0;
    end else begin
      gnt_q       <= '0;
      respValid_q <= 1'b0;
      sigStart_q  <= 1'b0;
      abort_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (anyReq_d) begin
            gnt_q  <= GNT_LSB << winner_d;
            id_q   <= winner_d;
            busy_q <= 1'b1;
            if (isSaturated(winOp_d, SAT_EXP)) begin
              respData_q  <= saturatedValue(winOp_d);
              respErr_q   <= 1'b0;
              respId_q    <= winner_d;
              respValid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              sigStart_q <= 1'b1;
              sigNum_q   <= winOp_d;
              state_q    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the last permitted cycle still counts as success.
          if (sig_done_i) begin
            respData_q  <= sig_result_i;
            respErr_q   <= 1'b0;
            respId_q    <= id_q;
            respValid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (wcnt_q == WCNT_LAST) begin
            respData_q  <= FP_QNAN;
            respErr_q   <= 1'b1;
            respId_q    <= id_q;
            respValid_q <= 1'b1;
            abort_q     <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        S_RESP: begin
          rrPtr_q <= nextPtr_d;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o        = gnt_q;
  assign resp_valid_o = respValid_q;
  assign resp_id_o    = respId_q;
  assign resp_data_o  = respData_q;
  assign resp_err_o   = respErr_q;
  assign busy_o       = busy_q;
  assign sig_start_o  = sigStart_q;
  assign sig_num_o    = sigNum_q;
  assign sig_res_o    = res_i | abort_q;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Self-checking bench: an event-scheduling job model checked every cycle,
// plus directed scenarios pinned with hand-computed literal expectations.
module tb_sigmoid_arbiter;

  localparam int          N_REQ       = 4;
  localparam int          TIMEOUT     = 16;
  localparam int          SAT_EXP     = 130;
  localparam int          ID_W        = 2;
  localparam logic [31:0] UNIT_RESULT = 32'h3F3B26A8;
  localparam logic [31:0] IDLE_RESULT = 32'hDEADBEEF;

  logic                clk = 1'b0;
  logic                res = 1'b1;
  logic [N_REQ-1:0]    req = '0;
  logic [31:0]         ops [N_REQ];
  logic [32*N_REQ-1:0] reqNum;
  logic [N_REQ-1:0]    gnt;
  logic                respValid;
  logic [ID_W-1:0]     respId;
  logic [31:0]         respData;
  logic                respErr;
  logic                busy;
  logic                sigStart;
  logic [31:0]         sigNum;
  logic                sigDone = 1'b0;
  logic [31:0]         sigResult = IDLE_RESULT;
  logic                sigRes;
  logic                strayDone = 1'b0;

  int unitLatency = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  assign reqNum = {ops[3], ops[2], ops[1], ops[0]};

  sigmoid_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .SAT_EXP(SAT_EXP)) dut (
    .clk_i        (clk),
    .res_i        (res),
    .req_i        (req),
    .req_num_i    (reqNum),
    .gnt_o        (gnt),
    .resp_valid_o (respValid),
    .resp_id_o    (respId),
    .resp_data_o  (respData),
    .resp_err_o   (respErr),
    .busy_o       (busy),
    .sig_start_o  (sigStart),
    .sig_num_o    (sigNum),
    .sig_done_i   (sigDone),
    .sig_result_i (sigResult),
    .sig_res_o    (sigRes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, expv);
    end
  endtask

  // Sigmoid unit stand-in: completes unitLatency cycles after a start, 0 = never.
  int doneAt = -1;
  always @(posedge clk) begin
    #2;
    if (sigStart) doneAt = (unitLatency > 0) ? cyc + unitLatency : -1;
    sigDone   = (cyc == doneAt) || strayDone;
    sigResult = sigDone ? UNIT_RESULT : IDLE_RESULT;
  end

  bit          armed = 0;
  bit          jobOn = 0;
  bit          jBypass, jTimeout, jErr;
  int          jGrant, jResp, jId;
  int          mPtr = 0;
  int          freeCyc = 0;
  logic [31:0] jNum, jData;

  int          gntIdxLog[$];
  int          respCycLog[$];
  int          respIdLog[$];
  int          startCycLog[$];
  int          abortCycLog[$];
  logic [31:0] respDataLog[$];
  logic        respErrLog[$];

  always @(negedge clk) begin : scoreboard
    logic [N_REQ-1:0] expGnt;
    logic             expValid;
    int               idx;
    if (armed) begin
      expGnt   = (jobOn && cyc == jGrant) ? (N_REQ'(1) << jId) : '0;
      expValid = jobOn && cyc == jResp;
      checkOutput("gnt", 32'(gnt), 32'(expGnt));
      checkOutput("sig_start", 32'(sigStart), 32'(jobOn && !jBypass && cyc == jGrant));
      checkOutput("resp_valid", 32'(respValid), 32'(expValid));
      checkOutput("busy", 32'(busy), 32'(jobOn && cyc >= jGrant && cyc <= jResp));
      checkOutput("sig_res", 32'(sigRes), 32'(res || (jobOn && jTimeout && cyc == jResp)));
      if (expValid) begin
        checkOutput("resp_id", 32'(respId), 32'(jId));
        checkOutput("resp_data", respData, jData);
        checkOutput("resp_err", 32'(respErr), 32'(jErr));
      end
      if (jobOn && !jBypass && cyc >= jGrant && cyc <= jResp)
        checkOutput("sig_num", sigNum, jNum);
    end
    if (gnt != '0) begin
      idx = -1;
      for (int k = N_REQ - 1; k >= 0; k--) if (gnt[k]) idx = k;
      gntIdxLog.push_back(idx);
    end
    if (sigStart) startCycLog.push_back(cyc);
    if (sigRes && !res) abortCycLog.push_back(cyc);
    if (respValid) begin
      respCycLog.push_back(cyc);
      respIdLog.push_back(int'(respId));
      respDataLog.push_back(respData);
      respErrLog.push_back(respErr);
    end
    // Model: a job accepted in cycle c is fully scheduled from the latency rules.
    if (res) begin
      jobOn   = 0;
      mPtr    = 0;
      freeCyc = cyc + 1;
      armed   = 1;
    end else if (armed && cyc >= freeCyc && req != '0) begin
      idx = -1;
      for (int k = 0; k < N_REQ; k++)
        if (idx < 0 && req[(mPtr + k) % N_REQ]) idx = (mPtr + k) % N_REQ;
      jId      = idx;
      jGrant   = cyc + 1;
      jBypass  = ops[idx][30:23] > 8'(SAT_EXP);
      jTimeout = 0;
      jErr     = 0;
      jNum     = ops[idx];
      if (jBypass) begin
        jResp = cyc + 1;
        jData = ops[idx][31] ? 32'h0000_0000 : 32'h3F80_0000;
      end else if (unitLatency >= 1 && unitLatency <= TIMEOUT) begin
        jResp = cyc + 2 + unitLatency;
        jData = UNIT_RESULT;
      end else begin
        jResp    = cyc + 2 + TIMEOUT;
        jData    = 32'h7FC0_0000;
        jErr     = 1;
        jTimeout = 1;
      end
      freeCyc = jResp + 1;
      mPtr    = (idx + 1) % N_REQ;
      jobOn   = 1;
    end
  end

  task automatic doReset();
    res = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Drives reqVec from the current cycle until nResp responses arrive; returns the start cycle.
  task automatic applyStimulus(input logic [N_REQ-1:0] reqVec, input bit hold,
                               input int nResp, output int t);
    int base;
    base = respCycLog.size();
    req  = reqVec;
    t    = cyc;
    for (int k = 0; k < 40 * nResp; k++) begin
      @(posedge clk);
      #1;
      if (!hold) req = req & ~gnt;
      if (respCycLog.size() >= base + nResp) break;
    end
    req = '0;
    if (respCycLog.size() < base + nResp) begin
      checks++;
      errors++;
      $display("[TB] FAIL response_wait cyc=%0d got=%0d responses expected=%0d", cyc,
               respCycLog.size() - base, nResp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog cyc=%0d simulation did not finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, g0, s0, a0, r0;
    for (int i = 0; i < N_REQ; i++) ops[i] = 32'h3F00_0000;
    doReset();

    $display("[TB] single request");
    unitLatency = 5;
    ops[0] = 32'h3F80_0000;
    applyStimulus(4'b0001, 0, 1, t);
    checkOutput("t1_start_lat", 32'(startCycLog[$] - t), 32'd1);
    checkOutput("t1_resp_lat", 32'(respCycLog[$] - t), 32'd7);
    checkOutput("t1_resp_id", 32'(respIdLog[$]), 32'd0);
    checkOutput("t1_resp_data", respDataLog[$], 32'h3F3B26A8);
    checkOutput("t1_resp_err", 32'(respErrLog[$]), 32'd0);

    $display("[TB] fairness");
    doReset();
    unitLatency = 2;
    ops[0] = 32'h3F00_0000;
    g0 = gntIdxLog.size();
    applyStimulus(4'b1111, 1, 5, t);
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("t2_order%0d", k), 32'(gntIdxLog[g0 + k]), 32'(k % 4));
    applyStimulus(4'b0010, 0, 1, t);
    g0 = gntIdxLog.size();
    applyStimulus(4'b1010, 1, 2, t);
    checkOutput("t2_ptr2_first", 32'(gntIdxLog[g0]), 32'd3);
    checkOutput("t2_ptr2_second", 32'(gntIdxLog[g0 + 1]), 32'd1);

    $display("[TB] bypass");
    s0 = startCycLog.size();
    ops[2] = 32'h4190_0000;
    applyStimulus(4'b0100, 0, 1, t);
    checkOutput("t3_pos_lat", 32'(respCycLog[$] - t), 32'd1);
    checkOutput("t3_pos_data", respDataLog[$], 32'h3F80_0000);
    ops[2] = 32'hC190_0000;
    applyStimulus(4'b0100, 0, 1, t);
    checkOutput("t3_neg_data", respDataLog[$], 32'h0000_0000);
    ops[3] = 32'h7FC0_0000;
    applyStimulus(4'b1000, 0, 1, t);
    checkOutput("t3_nan_data", respDataLog[$], 32'h3F80_0000);
    ops[3] = 32'hFF80_0000;
    applyStimulus(4'b1000, 0, 1, t);
    checkOutput("t3_ninf_data", respDataLog[$], 32'h0000_0000);
    checkOutput("t3_no_start", 32'(startCycLog.size() - s0), 32'd0);
    unitLatency = 3;
    ops[0] = 32'h4100_0000;
    applyStimulus(4'b0001, 0, 1, t);
    checkOutput("t3_exp130_lat", 32'(respCycLog[$] - t), 32'd5);
    ops[0] = 32'h4180_0000;
    applyStimulus(4'b0001, 0, 1, t);
    checkOutput("t3_exp131_lat", 32'(respCycLog[$] - t), 32'd1);

    $display("[TB] timeout");
    unitLatency = 0;
    a0 = abortCycLog.size();
    ops[1] = 32'h3F80_0000;
    applyStimulus(4'b0010, 0, 1, t);
    checkOutput("t4_lat", 32'(respCycLog[$] - t), 32'd18);
    checkOutput("t4_err", 32'(respErrLog[$]), 32'd1);
    checkOutput("t4_data", respDataLog[$], 32'h7FC0_0000);
    checkOutput("t4_pulses", 32'(abortCycLog.size() - a0), 32'd1);
    if (abortCycLog.size() > a0)
      checkOutput("t4_pulse_cyc", 32'(abortCycLog[a0] - t), 32'd18);
    unitLatency = 4;
    ops[0] = 32'h3F80_0000;
    applyStimulus(4'b0001, 0, 1, t);
    checkOutput("t4_next_lat", 32'(respCycLog[$] - t), 32'd6);
    checkOutput("t4_next_err", 32'(respErrLog[$]), 32'd0);

    $display("[TB] coincident done and timeout");
    unitLatency = 16;
    a0 = abortCycLog.size();
    applyStimulus(4'b0001, 0, 1, t);
    checkOutput("t5_lat", 32'(respCycLog[$] - t), 32'd18);
    checkOutput("t5_err", 32'(respErrLog[$]), 32'd0);
    checkOutput("t5_data", respDataLog[$], UNIT_RESULT);
    checkOutput("t5_no_pulse", 32'(abortCycLog.size() - a0), 32'd0);

    $display("[TB] reset during wait");
    unitLatency = 0;
    r0 = respCycLog.size();
    g0 = gntIdxLog.size();
    ops[2] = 32'h3F80_0000;
    req = 4'b0100;
    repeat (5) begin
      @(posedge clk);
      #1 req = req & ~gnt;
    end
    checkOutput("t6_granted2", 32'(gntIdxLog[g0]), 32'd2);
    res = 1'b1;
    @(posedge clk);
    #1 res = 1'b0;
    checkOutput("t6_busy_cleared", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1 strayDone = 1'b1;
    @(posedge clk);
    #1 strayDone = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    checkOutput("t6_no_resp", 32'(respCycLog.size() - r0), 32'd0);
    ops[0] = 32'h4190_0000;
    ops[2] = 32'h4190_0000;
    g0 = gntIdxLog.size();
    applyStimulus(4'b0101, 0, 1, t);
    checkOutput("t6_regrant0", 32'(gntIdxLog[g0]), 32'd0);
    checkOutput("t6_resp_id", 32'(respIdLog[$]), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sigmoid_arbiter.md
Name: sigmoid_arbiter

Overview:
- Round-robin scheduler that shares one FP32 sigmoid evaluation unit between N_REQ requesters.
- Per request it latches the operand, starts the unit, waits for completion or timeout, and returns the result tagged with the requester ID.
- Saturated operands (|x| >= 16) bypass the unit entirely and return 1.0 or 0.0.
- Sits between the neuron/activation stages and the single sigmoid datapath instance.

Parameters:
- N_REQ, 4, number of requesters (2..8); ID_W = clog2(N_REQ), derived localparam.
- TIMEOUT, 16, maximum WAIT cycles before a job is aborted (>= 8).
- SAT_EXP, 130, biased-exponent threshold; operands with exp > SAT_EXP bypass the unit.

Ports:
- clk  in  1  system clock, rising-edge.
- res  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-requester request; held with operand until matching gnt seen.
- req_num  in  32*N_REQ  FP32 operands, requester i at bits [32i+31:32i].
- gnt  out  N_REQ  one-hot, 1-cycle pulse: operand captured.
- resp_valid  out  1  1-cycle result strobe.
- resp_id  out  ID_W  requester index of the result.
- resp_data  out  32  FP32 sigmoid result.
- resp_err  out  1  job timed out; resp_data = 32'h7FC00000.
- busy  out  1  high in every state except IDLE.
- sig_start  out  1  1-cycle start pulse to the sigmoid unit.
- sig_num  out  32  operand to the unit, stable from ISSUE until return to IDLE.
- sig_done  in  1  unit completion strobe.
- sig_result  in  32  unit result, valid while sig_done=1.
- sig_res  out  1  unit reset = res OR registered abort pulse.

Behaviour:
- Clocking and reset: one clock (clk); res is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, and gnt, resp_valid, resp_id, resp_data, resp_err, sig_start, sig_num, busy, abort all 0. sig_res=1 while res=1.
- Reset mid-operation aborts the job with no response. A late sig_done arriving in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered except sig_res.
- IDLE:
  - When req != 0, the winner is the first set bit at or above rr_ptr, wrapping modulo N_REQ.
  - At that edge: gnt[winner]<=1, op_q<=req_num[winner], id_q<=winner.
  - If op_q exp[30:23] > SAT_EXP: resp_data <= sign ? 32'h00000000 : 32'h3F800000, next=RESP (bypass; the unit is untouched).
  - Otherwise next=ISSUE.
- ISSUE: 1 cycle. sig_start=1, sig_num=op_q, gnt visible this cycle. wcnt<=0, next=WAIT.
- WAIT:
  - sig_done=1: resp_data<=sig_result, resp_err<=0, next=RESP.
  - Else if wcnt==TIMEOUT-1: resp_data<=32'h7FC00000, resp_err<=1, abort<=1, next=RESP.
  - Else wcnt++.
  - If sig_done and timeout occur in the same cycle, sig_done wins.
- RESP: 1 cycle. resp_valid=1, resp_id=id_q. rr_ptr<=id_q+1 mod N_REQ. next=IDLE. abort clears at the next edge, so sig_res is a 1-cycle pulse.
- Latency, request seen in IDLE at cycle t:
  - Bypass: resp_valid at t+1.
  - Normal: sig_start at t+1; with sig_done in cycle d, resp_valid at d+1.
  - Timeout: resp_valid at t+2+TIMEOUT.
- Only one job is in flight. req is ignored outside IDLE. A new grant can be issued in the IDLE cycle after RESP, i.e. 1 idle cycle minimum between jobs.
- NaN/Inf operands (exp=255) take the bypass path and return a sign-based saturation value.
- rr_ptr advances only on RESP, including bypass and error responses.

Decomposition:
- Shared package sigmoid_pkg holds: FP32 constants (FP_ONE=32'h3F800000, FP_ZERO, FP_QNAN=32'h7FC00000), the state encoding, and the SAT_EXP default.
- One sub-module, rr_picker: combinational round-robin winner select taking req and rr_ptr, producing a winner index and any-flag.

Test Plan:
1. Single request: req=4'b0001, num=32'h3F800000 (1.0); unit model asserts done 5 cycles after start with 32'h3F3B26A8 -> sig_start at t+1, resp_valid at t+7, resp_id=0, resp_data=32'h3F3B26A8, resp_err=0.
2. Fairness: req=4'b1111 held continuously after reset -> grant order 0,1,2,3,0. With req=4'b1010 and rr_ptr=2 -> grant 3, then 1.
3. Bypass: num=32'h41900000 (18.0) -> resp_valid at t+1, data 32'h3F800000, no sig_start. num=32'hC1900000 -> data 32'h00000000.
4. Timeout: unit never asserts done, TIMEOUT=16 -> resp_valid at t+18, resp_err=1, data 32'h7FC00000, single-cycle sig_res pulse, next request served normally.
5. Coincidence: sig_done asserted on the final WAIT cycle (wcnt=15) -> resp_err=0, data=sig_result, no sig_res pulse.
6. Reset in WAIT: res=1 for 1 cycle -> no resp_valid. busy=0 and rr_ptr=0 next cycle. A later sig_done is ignored, and a new request is granted to index 0.
